// File: rtl/sampling_pkg.sv
// Shared state encoding and record-packing helpers for the sample_engine frame sampler.
package sampling_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        EVAL,
        WRITE,
        DONE
    } state_t;

    // Widest record pack_record can assemble; DATAWIDTH must stay below this.
    localparam int MAX_REC = 1024;

    function automatic int lane_width(input int pairs);
        return (pairs <= 2) ? 1 : $clog2(pairs);
    endfunction

    // Sign in the top bit, lane index just above the word address, zeros elsewhere.
    function automatic logic [MAX_REC-1:0] pack_record(
        input logic        sgn,
        input logic [31:0] lane,
        input logic [31:0] addr,
        input int          dw,
        input int          lw,
        input int          aw
    );
        logic [MAX_REC-1:0] addr_mask;
        logic [MAX_REC-1:0] lane_mask;
        logic [MAX_REC-1:0] rec;
        addr_mask = (MAX_REC'(1) << aw) - MAX_REC'(1);
        lane_mask = (MAX_REC'(1) << lw) - MAX_REC'(1);
        rec = (MAX_REC'(addr) & addr_mask) | ((MAX_REC'(lane) & lane_mask) << aw);
        rec = rec | (MAX_REC'(sgn) << (dw - 1));
        return rec;
    endfunction

endpackage

// File: rtl/pair_absdiff.sv
// Absolute difference of one pixel pair and a strict (exclusive) threshold-band test.
module pair_absdiff #(
    parameter int PIXWIDTH = 16
) (
    input  logic [PIXWIDTH-1:0] a,
    input  logic [PIXWIDTH-1:0] b,
    input  logic [PIXWIDTH-1:0] thr_lo,
    input  logic [PIXWIDTH-1:0] thr_hi,
    output logic [PIXWIDTH:0]   diff,
    output logic                sgn,
    output logic                hit
);

    // One extra bit keeps the subtraction and compares free of wrap.
    always_comb begin
        sgn  = (a > b);
        diff = sgn ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
        hit  = ({1'b0, thr_lo} < diff) && (diff < {1'b0, thr_hi});
    end

endmodule

// File: rtl/sample_engine.sv
// Streams a window of packed pixel words, tests every pair against a threshold band
// and writes one address record per hit into sample SRAM.
module sample_engine
    import sampling_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int PIXWIDTH  = 16,
    parameter int PAIRS     = DATAWIDTH / (2 * PIXWIDTH),
    parameter int ADDR      = 14,
    parameter int SDEPTH    = 1200,
    parameter int SADDR     = $clog2(SDEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR-1:0]      fbase,
    input  logic [ADDR:0]        flen,
    input  logic [PIXWIDTH-1:0]  thr_lo,
    input  logic [PIXWIDTH-1:0]  thr_hi,
    output logic                 load,
    output logic [ADDR-1:0]      faddr,
    input  logic [DATAWIDTH-1:0] fdata,
    output logic                 store,
    output logic [SADDR-1:0]     saddr,
    output logic [DATAWIDTH-1:0] sdata,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic [SADDR:0]       hit_count
);

    localparam int             LW         = lane_width(PAIRS);
    localparam logic [SADDR:0] FULL_COUNT = (SADDR + 1)'(SDEPTH);

    state_t               state;
    state_t               state_next;

    logic [ADDR-1:0]      cur_addr;
    logic [ADDR:0]        words_left;
    logic [ADDR-1:0]      word_addr;
    logic [PIXWIDTH-1:0]  thr_lo_q;
    logic [PIXWIDTH-1:0]  thr_hi_q;
    logic [PAIRS-1:0]     mask;
    logic [PAIRS-1:0]     sgn_q;
    logic [SADDR:0]       hit_count_q;
    logic                 overflow_q;

    logic [PAIRS-1:0]     pair_hit;
    logic [PAIRS-1:0]     pair_sgn;
    logic [PIXWIDTH:0]    diff_unused [PAIRS];

    logic [LW-1:0]        low_lane;
    logic                 low_sgn;
    logic [PAIRS-1:0]     low_onehot;
    logic [PAIRS-1:0]     mask_rest;
    logic                 full;
    logic                 more_words;
    logic [MAX_REC-1:0]   rec_full;
    logic                 unused_rec;

    // Magnitudes stay visible on the lane instances for debug; only hit and sign drive the engine.
    for (genvar p = 0; p < PAIRS; p++) begin : g_pair
        pair_absdiff #(
            .PIXWIDTH (PIXWIDTH)
        ) u_pair (
            .a      (fdata[(2*p+2)*PIXWIDTH-1 -: PIXWIDTH]),
            .b      (fdata[(2*p+1)*PIXWIDTH-1 -: PIXWIDTH]),
            .thr_lo (thr_lo_q),
            .thr_hi (thr_hi_q),
            .diff   (diff_unused[p]),
            .sgn    (pair_sgn[p]),
            .hit    (pair_hit[p])
        );
    end

    // Descending scan so the lowest pending lane is the one left standing.
    always_comb begin
        low_lane = '0;
        low_sgn  = 1'b0;
        for (int i = PAIRS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                low_lane = LW'(i);
                low_sgn  = sgn_q[i];
            end
        end
    end

    assign low_onehot = mask & (~mask + PAIRS'(1));
    assign mask_rest  = mask & ~low_onehot;
    assign full       = (hit_count_q == FULL_COUNT);
    assign more_words = (words_left != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (flen == '0) ? DONE : READ;
                end
            end
            READ: state_next = EVAL;
            EVAL: begin
                if (pair_hit != '0) begin
                    state_next = WRITE;
                end else begin
                    state_next = more_words ? READ : DONE;
                end
            end
            WRITE: begin
                if (full) begin
                    state_next = DONE;
                end else if (mask_rest == '0) begin
                    state_next = more_words ? READ : DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Run parameters are captured on start so the caller may change them mid-scan.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_addr    <= '0;
            words_left  <= '0;
            word_addr   <= '0;
            thr_lo_q    <= '0;
            thr_hi_q    <= '0;
            mask        <= '0;
            sgn_q       <= '0;
            hit_count_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cur_addr    <= fbase;
                        words_left  <= flen;
                        thr_lo_q    <= thr_lo;
                        thr_hi_q    <= thr_hi;
                        mask        <= '0;
                        hit_count_q <= '0;
                        overflow_q  <= 1'b0;
                    end
                end
                READ: begin
                    word_addr  <= cur_addr;
                    cur_addr   <= cur_addr + 1'b1;
                    words_left <= words_left - 1'b1;
                end
                EVAL: begin
                    mask  <= pair_hit;
                    sgn_q <= pair_sgn;
                end
                WRITE: begin
                    if (full) begin
                        overflow_q <= 1'b1;
                    end else begin
                        mask        <= mask_rest;
                        hit_count_q <= hit_count_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rec_full   = pack_record(low_sgn, 32'(low_lane), 32'(word_addr), DATAWIDTH, LW, ADDR);
    assign unused_rec = ^rec_full[MAX_REC-1:DATAWIDTH];

    assign load      = (state == READ);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign faddr     = cur_addr;
    assign store     = (state == WRITE) && !full;
    assign saddr     = store ? hit_count_q[SADDR-1:0] : '0;
    assign sdata     = store ? rec_full[DATAWIDTH-1:0] : '0;
    assign overflow  = overflow_q;
    assign hit_count = hit_count_q;

endmodule

// File: tb/tb_sample_engine.sv
// Directed scoreboard bench: a 32-bit single-pair engine and a 64-bit two-pair engine with a 4-record sample SRAM.
module tb_sample_engine;

    typedef struct packed {
        logic [15:0] addr;
        logic [63:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        start_a, load_a, store_a, busy_a, done_a, overflow_a;
    logic [13:0] fbase_a, faddr_a;
    logic [14:0] flen_a;
    logic [15:0] thr_lo_a, thr_hi_a;
    logic [31:0] fdata_a, sdata_a;
    logic [10:0] saddr_a;
    logic [11:0] hit_count_a;

    logic        start_b, load_b, store_b, busy_b, done_b, overflow_b;
    logic [13:0] fbase_b, faddr_b;
    logic [14:0] flen_b;
    logic [15:0] thr_lo_b, thr_hi_b;
    logic [63:0] fdata_b, sdata_b;
    logic [1:0]  saddr_b;
    logic [2:0]  hit_count_b;

    logic [31:0] mem_a [16384];
    logic [63:0] mem_b [16384];

    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [63:0] store_log_a[$];
    logic [63:0] store_log_b[$];
    logic [13:0] load_log_a[$];
    int          exp_hits [2];
    bit          exp_ovf [2];
    int          n_compared = 0;
    int          n_mismatch = 0;
    int          cycles;

    sample_engine u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .start     (start_a),
        .fbase     (fbase_a),
        .flen      (flen_a),
        .thr_lo    (thr_lo_a),
        .thr_hi    (thr_hi_a),
        .load      (load_a),
        .faddr     (faddr_a),
        .fdata     (fdata_a),
        .store     (store_a),
        .saddr     (saddr_a),
        .sdata     (sdata_a),
        .busy      (busy_a),
        .done      (done_a),
        .overflow  (overflow_a),
        .hit_count (hit_count_a)
    );

    sample_engine #(
        .DATAWIDTH (64),
        .SDEPTH    (4)
    ) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .start     (start_b),
        .fbase     (fbase_b),
        .flen      (flen_b),
        .thr_lo    (thr_lo_b),
        .thr_hi    (thr_hi_b),
        .load      (load_b),
        .faddr     (faddr_b),
        .fdata     (fdata_b),
        .store     (store_b),
        .saddr     (saddr_b),
        .sdata     (sdata_b),
        .busy      (busy_b),
        .done      (done_b),
        .overflow  (overflow_b),
        .hit_count (hit_count_b)
    );

    // Frame SRAM models: read data valid one cycle after the strobe.
    always @(posedge clk) begin
        if (load_a) fdata_a <= mem_a[faddr_a];
        if (load_b) fdata_b <= mem_b[faddr_b];
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatch++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Stores are popped against the scoreboard as they appear.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (store_a) begin
            store_log_a.push_back(64'(sdata_a));
            checkOutput("a_store_expected", 64'(q_a.size() != 0), 64'd1);
            if (q_a.size() != 0) begin
                e = q_a.pop_front();
                checkOutput("a_saddr", 64'(saddr_a), 64'(e.addr));
                checkOutput("a_sdata", 64'(sdata_a), e.data);
            end
        end
        if (store_b) begin
            store_log_b.push_back(sdata_b);
            checkOutput("b_store_expected", 64'(q_b.size() != 0), 64'd1);
            if (q_b.size() != 0) begin
                e = q_b.pop_front();
                checkOutput("b_saddr", 64'(saddr_b), 64'(e.addr));
                checkOutput("b_sdata", sdata_b, e.data);
            end
        end
        if (load_a) load_log_a.push_back(faddr_a);
    end

    task automatic model_run(input bit which, input int base, input int len, input int lo, input int hi);
        int          depth;
        int          pairs;
        int          hits;
        int          diff;
        int          addr;
        bit          ovf;
        logic [63:0] word;
        logic [15:0] a;
        logic [15:0] b;
        exp_t        e;
        depth = which ? 4 : 1200;
        pairs = which ? 2 : 1;
        hits  = 0;
        ovf   = 1'b0;
        for (int w = 0; w < len && !ovf; w++) begin
            addr = (base + w) % 16384;
            word = which ? mem_b[addr] : {32'h0, mem_a[addr]};
            for (int p = 0; p < pairs && !ovf; p++) begin
                a    = word[p*32+16 +: 16];
                b    = word[p*32 +: 16];
                diff = (a > b) ? int'(a) - int'(b) : int'(b) - int'(a);
                if (lo < diff && diff < hi) begin
                    if (hits == depth) begin
                        ovf = 1'b1;
                    end else begin
                        e.addr = 16'(hits);
                        e.data = (64'(a > b) << (which ? 63 : 31)) | (64'(p) << 14) | 64'(addr);
                        if (which) q_b.push_back(e);
                        else q_a.push_back(e);
                        hits++;
                    end
                end
            end
        end
        exp_hits[which] = hits;
        exp_ovf[which]  = ovf;
    endtask

    // Pulses start, then scrambles the run inputs to show they were captured.
    task automatic applyStimulus(input bit which, input int base, input int len, input int lo, input int hi);
        @(negedge clk);
        if (which) begin
            q_b.delete();
            store_log_b.delete();
            fbase_b = 14'(base); flen_b = 15'(len); thr_lo_b = 16'(lo); thr_hi_b = 16'(hi);
            start_b = 1'b1;
        end else begin
            q_a.delete();
            store_log_a.delete();
            load_log_a.delete();
            fbase_a = 14'(base); flen_a = 15'(len); thr_lo_a = 16'(lo); thr_hi_a = 16'(hi);
            start_a = 1'b1;
        end
        model_run(which, base, len, lo, hi);
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        fbase_a = 14'h1555; flen_a = 15'h7FFF; thr_lo_a = 16'h0; thr_hi_a = 16'hFFFF;
        fbase_b = 14'h1555; flen_b = 15'h7FFF; thr_lo_b = 16'h0; thr_hi_b = 16'hFFFF;
    endtask

    task automatic wait_done(input bit which, input string tag, output int cyc);
        cyc = 1;
        while (!(which ? done_b : done_a) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput({tag, "_done_seen"}, 64'(which ? done_b : done_a), 64'd1);
        checkOutput({tag, "_hit_count"}, 64'(which ? hit_count_b : hit_count_a), 64'(exp_hits[which]));
        checkOutput({tag, "_overflow"}, 64'(which ? overflow_b : overflow_a), 64'(exp_ovf[which]));
        checkOutput({tag, "_stores"}, 64'(which ? store_log_b.size() : store_log_a.size()), 64'(exp_hits[which]));
        checkOutput({tag, "_queue_left"}, 64'(which ? q_b.size() : q_a.size()), 64'd0);
        @(negedge clk);
        checkOutput({tag, "_busy_after"}, 64'(which ? busy_b : busy_a), 64'd0);
        checkOutput({tag, "_done_after"}, 64'(which ? done_b : done_a), 64'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0;
        start_a = 1'b0; fbase_a = '0; flen_a = '0; thr_lo_a = '0; thr_hi_a = '0;
        start_b = 1'b0; fbase_b = '0; flen_b = '0; thr_lo_b = '0; thr_hi_b = '0;
        for (int i = 0; i < 16384; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 64'(busy_a), 64'd0);
        checkOutput("reset_load", 64'(load_a), 64'd0);
        checkOutput("reset_store", 64'(store_a), 64'd0);
        checkOutput("reset_hit_count", 64'(hit_count_a), 64'd0);
        checkOutput("reset_overflow", 64'(overflow_a), 64'd0);
        rst = 1'b1;

        $display("[TB] single pair, one hit, high-side reject");
        mem_a[0] = 32'h0100_0000; mem_a[1] = 32'h0000_0010; mem_a[2] = 32'h8000_0000;
        applyStimulus(1'b0, 0, 3, 100, 30000);
        wait_done(1'b0, "t1", cycles);
        checkOutput("t1_done_cycle", 64'(cycles), 64'd8);
        checkOutput("t1_hits_const", 64'(hit_count_a), 64'd1);
        if (store_log_a.size() != 0) checkOutput("t1_record", store_log_a[0], 64'h8000_0000);

        $display("[TB] equal pixels and diffs on both band edges");
        mem_a[10] = 32'h1234_1234; mem_a[11] = 32'h0064_0000; mem_a[12] = 32'h0000_00C8;
        applyStimulus(1'b0, 10, 3, 100, 200);
        wait_done(1'b0, "t2", cycles);
        checkOutput("t2_hits_const", 64'(hit_count_a), 64'd0);

        $display("[TB] two pairs hitting in one word");
        mem_b[5] = 64'h0000_0064_0200_0100;
        applyStimulus(1'b1, 5, 1, 10, 1000);
        wait_done(1'b1, "t3", cycles);
        checkOutput("t3_done_cycle", 64'(cycles), 64'd5);
        if (store_log_b.size() == 2) begin
            checkOutput("t3_lane0", store_log_b[0], 64'h8000_0000_0000_0005);
            checkOutput("t3_lane1", store_log_b[1], 64'h0000_0000_0000_4005);
        end

        $display("[TB] sample SRAM overflow");
        for (int i = 0; i < 10; i++) mem_b[100 + i] = 64'h0002_0001_0003_0004;
        applyStimulus(1'b1, 100, 10, 0, 65535);
        wait_done(1'b1, "t4", cycles);
        checkOutput("t4_done_cycle", 64'(cycles), 64'd12);
        checkOutput("t4_overflow_const", 64'(overflow_b), 64'd1);
        checkOutput("t4_hits_const", 64'(hit_count_b), 64'd4);

        $display("[TB] empty window and address wrap");
        applyStimulus(1'b0, 7, 0, 100, 30000);
        wait_done(1'b0, "t5a", cycles);
        checkOutput("t5a_done_cycle", 64'(cycles), 64'd1);
        checkOutput("t5a_loads", 64'(load_log_a.size()), 64'd0);
        mem_a[16383] = 32'h0;
        applyStimulus(1'b0, 16383, 2, 100, 30000);
        wait_done(1'b0, "t5b", cycles);
        checkOutput("t5b_loads", 64'(load_log_a.size()), 64'd2);
        if (load_log_a.size() == 2) begin
            checkOutput("t5b_faddr0", 64'(load_log_a[0]), 64'h3FFF);
            checkOutput("t5b_faddr1", 64'(load_log_a[1]), 64'h0000);
        end

        $display("[TB] asynchronous reset during WRITE");
        mem_a[20] = 32'h0100_0000; mem_a[21] = 32'h0200_0000; mem_a[22] = 32'h0000_0300;
        applyStimulus(1'b0, 20, 3, 100, 30000);
        cycles = 1;
        while (!store_a && cycles < 50) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("t6_store_seen", 64'(store_a), 64'd1);
        #2 rst = 1'b0;
        #1;
        checkOutput("t6_load", 64'(load_a), 64'd0);
        checkOutput("t6_store", 64'(store_a), 64'd0);
        checkOutput("t6_faddr", 64'(faddr_a), 64'd0);
        checkOutput("t6_saddr", 64'(saddr_a), 64'd0);
        checkOutput("t6_sdata", 64'(sdata_a), 64'd0);
        checkOutput("t6_busy", 64'(busy_a), 64'd0);
        checkOutput("t6_done", 64'(done_a), 64'd0);
        checkOutput("t6_hit_count", 64'(hit_count_a), 64'd0);
        checkOutput("t6_overflow_b", 64'(overflow_b), 64'd0);
        q_a.delete();
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, 20, 3, 100, 30000);
        wait_done(1'b0, "t6r", cycles);
        checkOutput("t6r_hits_const", 64'(hit_count_a), 64'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
